bw_io_dtl_cfg_shifter: RTL and testbench

Serial configuration loader for the DTL pad scan-flop chain. It accepts a parallel pad-configuration word, drives it bit-serially into the chain through the chain's scan-in/scan-enable inputs, and returns a completion pulse. It sits in the pad-common logic between the IOB configuration registers and the first DTL pad flop bank. Optionally, it captures the chain's previous contents from scan-out as readback.

---
 rtl/bw_io_dtl_cfg_shifter.sv | 168 ++++++++++++++++
 tb/tb_bw_io_dtl_cfg_shifter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bw_io_dtl_cfg_shifter.sv
// bw_io_dtl_cfg_shifter
//
// Serial configuration loader for the DTL pad scan-flop chain. A parallel
// pad-configuration word is latched on request and shifted MSB first into
// the chain. A one-cycle completion pulse follows the last shift.
//
// Optional feature, enabled by defining DTL_CFG_READBACK_EN:
//   The previous chain contents are captured from scan_so as readback.
//   A sticky error flag is raised when the readback differs from the word
//   loaded before it.
//
// Parameters:
//   CHAIN_LEN  number of scan flops in the chain (2..255)
//   CNT_W      shift-counter width, 2**CNT_W > CHAIN_LEN
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_l      asynchronous active-low reset
//   load_vld   request to load cfg_data
//   load_rdy   block is idle and accepts a request
//   cfg_data   configuration word, bit i lands in chain flop i
//   scan_si    registered serial data into the chain
//   scan_se    registered scan-enable to the chain
//   scan_so    serial data out of the last chain flop
//   done       one-cycle pulse when a load completes
//   rdbk_data  chain contents displaced by the last load (readback build)
//   rdbk_err   sticky readback mismatch flag (readback build)

module bw_io_dtl_cfg_shifter #(
    parameter int CHAIN_LEN = 24,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic                 load_vld,
    output logic                 load_rdy,
    input  logic [CHAIN_LEN-1:0] cfg_data,
    output logic                 scan_si,
    output logic                 scan_se,
    input  logic                 scan_so,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rdbk_data,
    output logic                 rdbk_err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]           state;
    logic [CHAIN_LEN-1:0] cfg_word;
    logic [CNT_W-1:0]     cnt;
    logic                 last_shift;
    logic                 next_si;

    assign load_rdy   = (state == IDLE);
    assign last_shift = (state == SHIFT) && (cnt == CNT_W'(CHAIN_LEN - 1));

    // The latched word is kept intact (not shifted) so it can also serve as
    // the "previous word" for readback. The bit presented after SHIFT
    // cycle cnt is cfg_word[CHAIN_LEN-2-cnt]; the MSB is loaded at accept.
    always_comb begin
        next_si = 1'b0;
        for (int i = 0; i < CHAIN_LEN - 1; i++) begin
            if (cnt == CNT_W'(CHAIN_LEN - 2 - i)) begin
                next_si = cfg_word[i];
            end
        end
    end

    // Main sequencer. scan_si/scan_se are registered here so the chain
    // sees clean flop outputs, and reset drops scan_se asynchronously.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= IDLE;
            cfg_word <= '0;
            cnt      <= '0;
            scan_si  <= 1'b0;
            scan_se  <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_vld) begin
                        cfg_word <= cfg_data;
                        cnt      <= '0;
                        state    <= SHIFT;
                        scan_se  <= 1'b1;
                        scan_si  <= cfg_data[CHAIN_LEN-1];
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (last_shift) begin
                        state   <= DONE;
                        scan_se <= 1'b0;
                        scan_si <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        scan_si <= next_si;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    scan_se <= 1'b0;
                    scan_si <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef DTL_CFG_READBACK_EN
    logic [CHAIN_LEN-1:0] rdbk_q;
    logic [CHAIN_LEN-1:0] rdbk_next;
    logic [CHAIN_LEN-1:0] prev_word;
    logic                 chain_vld;
    logic                 err_q;

    // On SHIFT cycle k the last flop holds the old contents of flop
    // CHAIN_LEN-1-k, so that is the readback bit written this edge.
    always_comb begin
        rdbk_next = rdbk_q;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            if ((state == SHIFT) && (cnt == CNT_W'(CHAIN_LEN - 1 - i))) begin
                rdbk_next[i] = scan_so;
            end
        end
    end

    // The comparison uses rdbk_next so the final bit captured on the
    // DONE-entry edge is included. Chain contents are unknown after reset
    // until one full load completes, hence chain_vld.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rdbk_q    <= '0;
            prev_word <= '0;
            chain_vld <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdbk_q <= rdbk_next;
            if (last_shift) begin
                if (chain_vld && (rdbk_next != prev_word)) begin
                    err_q <= 1'b1;
                end
                prev_word <= cfg_word;
                chain_vld <= 1'b1;
            end
        end
    end

    assign rdbk_data = rdbk_q;
    assign rdbk_err  = err_q;
`else
    logic [1:0] unused_bits;

    // Without readback the chain output and the latched MSB (only needed
    // at accept time from cfg_data directly) have no consumer.
    assign unused_bits = {scan_so, cfg_word[CHAIN_LEN-1]};
    assign rdbk_data   = '0;
    assign rdbk_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bw_io_dtl_cfg_shifter.sv
// tb_bw_io_dtl_cfg_shifter
//
// Self-checking bench for bw_io_dtl_cfg_shifter. A behavioural model of the
// scan chain sits on scan_si/scan_se/scan_so. Expected serial bits and final
// chain words are queued when a load is accepted and compared as the DUT
// shifts and pulses done. Readback expectations depend on
// DTL_CFG_READBACK_EN.

module tb_bw_io_dtl_cfg_shifter;

    localparam int N     = 24;
    localparam int CNT_W = 5;
`ifdef DTL_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_l;
    logic         load_vld;
    logic         load_rdy;
    logic [N-1:0] cfg_data;
    logic         scan_si;
    logic         scan_se;
    logic         scan_so;
    logic         done;
    logic [N-1:0] rdbk_data;
    logic         rdbk_err;

    logic [N-1:0] chain = '0;
    logic         flip_req;
    int           cyc = 0;

    int           tests_run = 0;
    int           failures  = 0;
    bit           sb_bits[$];
    logic [N-1:0] sb_chain[$];
    int           se_cnt = 0;
    int           accept_cyc = 0;
    int           first_cyc;

    bw_io_dtl_cfg_shifter #(.CHAIN_LEN(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .load_vld  (load_vld),
        .load_rdy  (load_rdy),
        .cfg_data  (cfg_data),
        .scan_si   (scan_si),
        .scan_se   (scan_se),
        .scan_so   (scan_so),
        .done      (done),
        .rdbk_data (rdbk_data),
        .rdbk_err  (rdbk_err)
    );

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scan chain model: flop 0 nearest scan_si, not reset by rst_l.
    // flip_req corrupts flop 5 while the chain is idle.
    always @(posedge clk) begin
        if (scan_se) begin
            chain <= {chain[N-2:0], scan_si};
        end else if (flip_req) begin
            chain[5] <= ~chain[5];
        end
    end

    assign scan_so = chain[N-1];

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to the next falling edge and check whatever the DUT
    // produced in the cycle just started against the scoreboard.
    task automatic step();
        @(negedge clk);
        if (!rst_l) begin
            sb_bits.delete();
            sb_chain.delete();
            se_cnt = 0;
        end else begin
            if (scan_se === 1'b1) begin
                se_cnt++;
                if (sb_bits.size() == 0) checkOutput("extra_shift", 1, 0);
                else checkOutput("scan_si", scan_si, sb_bits.pop_front());
            end
            if (done === 1'b1) begin
                checkOutput("se_len", se_cnt, N);
                se_cnt = 0;
                if (sb_chain.size() == 0) checkOutput("extra_done", 1, 0);
                else checkOutput("chain", chain, sb_chain.pop_front());
            end
        end
    endtask

    // Request a load, wait for acceptance and run until the done cycle.
    task automatic applyStimulus(input logic [N-1:0] word, input bit keep_vld,
                                 input bit toggle);
        int n;
        cfg_data = word;
        load_vld = 1'b1;
        n = 0;
        while (load_rdy !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (load_rdy !== 1'b1) begin
            checkOutput("rdy_timeout", 0, 1);
            load_vld = 1'b0;
            return;
        end
        for (int k = 0; k < N; k++) sb_bits.push_back(word[N-1-k]);
        sb_chain.push_back(word);
        step();
        accept_cyc = cyc;
        checkOutput("rdy_busy", load_rdy, 0);
        if (!keep_vld) load_vld = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < N + 4) begin
            if (toggle) cfg_data = N'($urandom);
            step();
            n++;
        end
        if (done !== 1'b1) begin
            checkOutput("done_timeout", 0, 1);
            return;
        end
        checkOutput("done_lat", cyc - accept_cyc, N);
        checkOutput("rdy_in_done", load_rdy, 0);
        checkOutput("se_in_done", scan_se, 0);
    endtask

    task automatic endLoad();
        step();
        checkOutput("done_pulse", done, 0);
        checkOutput("rdy_back", load_rdy, 1);
    endtask

    initial begin
        rst_l    = 1'b0;
        load_vld = 1'b0;
        cfg_data = '0;
        flip_req = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rdy", load_rdy, 1);
        checkOutput("rst_se", scan_se, 0);
        checkOutput("rst_si", scan_si, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_rdbk", rdbk_data, 0);
        checkOutput("rst_err", rdbk_err, 0);
        rst_l = 1'b1;
        step();

        // Single load
        applyStimulus(24'hA5C30F, 1'b0, 1'b0);
        endLoad();

        // Back-to-back with load_vld held high
        applyStimulus(24'h123456, 1'b1, 1'b0);
        first_cyc = accept_cyc;
        endLoad();
        applyStimulus(24'hFEDCBA, 1'b0, 1'b0);
        checkOutput("b2b_gap", accept_cyc - first_cyc, N + 2);
        endLoad();

        // cfg_data changing during SHIFT must not affect the shifted bits
        applyStimulus(24'h3C5A96, 1'b0, 1'b1);
        endLoad();

        // Clean readback
        applyStimulus(24'h0F0F0F, 1'b0, 1'b0);
        endLoad();
        applyStimulus(24'h00FF00, 1'b0, 1'b0);
        checkOutput("rdbk_clean", rdbk_data, RB ? 24'h0F0F0F : 24'h0);
        checkOutput("err_clean", rdbk_err, 0);
        endLoad();

        // Corrupted chain and sticky error
        applyStimulus(24'h111111, 1'b0, 1'b0);
        endLoad();
        flip_req = 1'b1;
        step();
        flip_req = 1'b0;
        applyStimulus(24'h222222, 1'b0, 1'b0);
        checkOutput("rdbk_corrupt", rdbk_data, RB ? 24'h111131 : 24'h0);
        checkOutput("err_set", rdbk_err, RB);
        endLoad();
        applyStimulus(24'h333333, 1'b0, 1'b0);
        checkOutput("err_sticky", rdbk_err, RB);
        endLoad();

        // Reset during SHIFT cycle 10
        cfg_data = 24'hC0FFEE;
        load_vld = 1'b1;
        for (int k = 0; k < N; k++) sb_bits.push_back(cfg_data[N-1-k]);
        step();
        load_vld = 1'b0;
        repeat (10) step();
        rst_l = 1'b0;
        #1;
        checkOutput("midrst_se", scan_se, 0);
        checkOutput("midrst_rdy", load_rdy, 1);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_err", rdbk_err, 0);
        step();
        checkOutput("midrst_no_done", done, 0);
        step();
        rst_l = 1'b1;
        applyStimulus(24'h000001, 1'b0, 1'b0);
        checkOutput("post_rst_err", rdbk_err, 0);
        endLoad();

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
